// File: rtl/muldiv_unit_if.sv
// Operand/request and result bundle between pipeline control (master) and the
// iterative multiply/divide unit (slave).
interface muldiv_unit_if;
   logic [31:0] a;
   logic [31:0] b;
   logic [1:0]  op;
   logic        start;
   logic        busy;
   logic        done;
   logic        dz;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output a, b, op, start, input busy, done, dz, hi, lo);
   modport slave  (input a, b, op, start, output busy, done, dz, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide: one radix-2 step per cycle on magnitudes,
// sign fix-up in a final cycle, results held in the HI/LO registers.
module muldiv_unit (
   input  logic         clk,
   input  logic         rst,
   muldiv_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic        is_div;
   logic        neg_q;     // product / quotient must be negated
   logic        neg_r;     // remainder must be negated (dividend was negative)
   logic        b_zero;
   logic [31:0] opa;       // multiplicand; for divide the dividend, replaced by quotient bits
   logic [31:0] opb;       // multiplier (consumed LSB-first) or divisor
   logic [63:0] acc;
   logic [31:0] rem;

   logic        busy_q;
   logic        done_q;
   logic        dz_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   logic        is_signed;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [32:0] mul_sum;
   logic [32:0] part;
   logic [31:0] diff;
   logic        q_bit;
   logic [63:0] prod;
   logic [31:0] quot;
   logic [31:0] remd;

   // NOTE: every variable here is assigned on every pass, so no latch can be inferred.
   always_comb begin
      is_signed = ~bus.op[0];
      mag_a     = (is_signed && bus.a[31]) ? -bus.a : bus.a;
      mag_b     = (is_signed && bus.b[31]) ? -bus.b : bus.b;
      mul_sum   = {1'b0, acc[63:32]} + (opb[0] ? {1'b0, opa} : 33'd0);
      part      = {rem, opa[31]};
      q_bit     = (part >= {1'b0, opb});
      diff      = part[31:0] - opb;
      prod      = neg_q ? -acc : acc;
      quot      = neg_q ? -opa : opa;
      remd      = neg_r ? -rem : rem;
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= 5'd0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         b_zero <= 1'b0;
         opa    <= 32'd0;
         opb    <= 32'd0;
         acc    <= 64'd0;
         rem    <= 32'd0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  is_div <= bus.op[1];
                  neg_q  <= is_signed & (bus.a[31] ^ bus.b[31]);
                  neg_r  <= is_signed & bus.a[31];
                  b_zero <= (bus.b == 32'd0);
                  opa    <= mag_a;
                  opb    <= mag_b;
                  acc    <= 64'd0;
                  rem    <= 32'd0;
                  cnt    <= 5'd0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (is_div) begin
                  // Restoring step: keep the trial difference only when it did not underflow.
                  rem <= q_bit ? diff : part[31:0];
                  opa <= {opa[30:0], q_bit};
               end else begin
                  acc <= {mul_sum, acc[31:1]};
                  opb <= {1'b0, opb[31:1]};
               end
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) state <= FIX;
            end
            FIX: begin
               if (is_div) begin
                  // A zero divisor naturally leaves |a| as remainder; only the quotient is forced.
                  lo_q <= b_zero ? 32'hFFFF_FFFF : quot;
                  hi_q <= remd;
                  dz_q <= b_zero;
               end else begin
                  {hi_q, lo_q} <= prod;
                  dz_q         <= 1'b0;
               end
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.dz   = dz_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed spec vectors plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;
   int   done_count  = 0;

   muldiv_unit_if bus ();

   muldiv_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.done === 1'b1) done_count++;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   // Reference: {hi, lo} from ordinary 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] res, qv, rv;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = 64'd0;
      case (op)
         2'd0: res = sa * sb;
         2'd1: res = {32'd0, a} * {32'd0, b};
         default: begin
            if (b == 32'd0) begin
               res = {a, 32'hFFFF_FFFF};
            end else begin
               if (op == 2'd2) begin
                  q = sa / sb;
                  r = sa % sb;
               end else begin
                  q = longint'({32'd0, a}) / longint'({32'd0, b});
                  r = longint'({32'd0, a}) % longint'({32'd0, b});
               end
               qv  = q;
               rv  = r;
               res = {rv[31:0], qv[31:0]};
            end
         end
      endcase
      return res;
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 6))
         0:       v = 32'd0;
         1:       v = 32'h8000_0000;
         2:       v = 32'hFFFF_FFFF;
         3:       v = 32'($urandom_range(0, 20));
         4:       v = -32'($urandom_range(1, 20));
         default: v = $urandom();
      endcase
      return v;
   endfunction

   // Launch one op and wait for done; lat counts edges after the start edge.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit at_negedge,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dz, output int lat);
      if (!at_negedge) @(negedge clk);
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = $urandom();
      bus.b     = $urandom();
      lat       = 0;
      while (bus.done !== 1'b1 && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         bus.a  = $urandom();
         bus.b  = $urandom();
         bus.op = 2'($urandom());
      end
      hi = bus.hi;
      lo = bus.lo;
      dz = bus.dz;
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.a     = 32'd0;
      bus.b     = 32'd0;
      bus.op    = 2'd0;
      rst       = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
      vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b expected 0", bus.done); end
      vectors++; if (bus.dz !== 1'b0)   begin miscompares++; $display("FAIL reset dz: got %b expected 0", bus.dz); end
      vectors++; if (bus.hi !== 32'd0)  begin miscompares++; $display("FAIL reset hi: got %h expected 0", bus.hi); end
      vectors++; if (bus.lo !== 32'd0)  begin miscompares++; $display("FAIL reset lo: got %h expected 0", bus.lo); end
   endtask

   task automatic test_directed();
      vec_t        tab [10];
      logic [31:0] hi, lo;
      logic        dz;
      int          lat;
      tab[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      tab[1] = '{2'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
      tab[2] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
      tab[3] = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
      tab[4] = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      tab[5] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
      tab[6] = '{2'd3, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
      tab[7] = '{2'd1, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0};
      tab[8] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
      tab[9] = '{2'd2, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1};
      for (int i = 0; i < 10; i++) begin
         do_op(tab[i].op, tab[i].a, tab[i].b, 1'b0, hi, lo, dz, lat);
         vectors++; if (lat !== 33)       begin miscompares++; $display("FAIL directed[%0d] latency: got %0d expected 33", i, lat); end
         vectors++; if (hi !== tab[i].hi) begin miscompares++; $display("FAIL directed[%0d] hi: got %h expected %h", i, hi, tab[i].hi); end
         vectors++; if (lo !== tab[i].lo) begin miscompares++; $display("FAIL directed[%0d] lo: got %h expected %h", i, lo, tab[i].lo); end
         vectors++; if (dz !== tab[i].dz) begin miscompares++; $display("FAIL directed[%0d] dz: got %b expected %b", i, dz, tab[i].dz); end
      end
   endtask

   task automatic test_ignore_busy_start();
      logic [31:0] prev_hi, prev_lo;
      int          lat, base;
      prev_hi = bus.hi;
      prev_lo = bus.lo;
      @(negedge clk);
      base      = done_count;
      bus.op    = 2'd2;
      bus.a     = 32'd1000;
      bus.b     = 32'd7;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      lat       = 0;
      while (bus.done !== 1'b1 && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         bus.a     = $urandom();
         bus.b     = $urandom();
         bus.op    = (lat == 10) ? 2'd3 : 2'($urandom());
         bus.start = (lat == 10);
         if (lat == 5) begin
            vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL busy during run: got %b expected 1", bus.busy); end
            vectors++; if (bus.hi !== prev_hi) begin miscompares++; $display("FAIL hi held during run: got %h expected %h", bus.hi, prev_hi); end
            vectors++; if (bus.lo !== prev_lo) begin miscompares++; $display("FAIL lo held during run: got %h expected %h", bus.lo, prev_lo); end
         end
      end
      bus.start = 1'b0;
      vectors++; if (lat !== 33)         begin miscompares++; $display("FAIL ignore-start latency: got %0d expected 33", lat); end
      vectors++; if (bus.lo !== 32'd142) begin miscompares++; $display("FAIL ignore-start lo: got %h expected %h", bus.lo, 32'd142); end
      vectors++; if (bus.hi !== 32'd6)   begin miscompares++; $display("FAIL ignore-start hi: got %h expected %h", bus.hi, 32'd6); end
      repeat (4) @(negedge clk);
      vectors++; if (done_count - base !== 1) begin miscompares++; $display("FAIL ignore-start done pulses: got %0d expected 1", done_count - base); end
      vectors++; if (bus.busy !== 1'b0)       begin miscompares++; $display("FAIL ignore-start busy after: got %b expected 0", bus.busy); end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
      logic [63:0] exp;
      logic        dz;
      int          lat;
      for (int i = 0; i < 5; i++) begin
         op = 2'($urandom());
         a  = pick();
         b  = pick();
         do_op(op, a, b, (i != 0), hi, lo, dz, lat);
         exp = model(op, a, b);
         vectors++; if (lat !== 33)                          begin miscompares++; $display("FAIL b2b[%0d] latency: got %0d expected 33", i, lat); end
         vectors++; if ({hi, lo} !== exp)                    begin miscompares++; $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got %h_%h expected %h", i, op, a, b, hi, lo, exp); end
         vectors++; if (dz !== (op[1] && b == 32'd0))        begin miscompares++; $display("FAIL b2b[%0d] dz: got %b expected %b", i, dz, op[1] && b == 32'd0); end
      end
   endtask

   task automatic test_abort();
      logic [31:0] hi, lo, a, b;
      logic [63:0] exp;
      logic        dz;
      int          lat, base;
      do_op(2'd3, 32'hCAFE_0001, 32'd0, 1'b0, hi, lo, dz, lat);
      @(negedge clk);
      bus.op    = 2'd0;
      bus.a     = $urandom();
      bus.b     = $urandom();
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      base = done_count;
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort busy: got %b expected 0", bus.busy); end
      vectors++; if (bus.hi !== 32'd0)  begin miscompares++; $display("FAIL abort hi: got %h expected 0", bus.hi); end
      vectors++; if (bus.lo !== 32'd0)  begin miscompares++; $display("FAIL abort lo: got %h expected 0", bus.lo); end
      vectors++; if (bus.dz !== 1'b0)   begin miscompares++; $display("FAIL abort dz: got %b expected 0", bus.dz); end
      repeat (40) @(negedge clk);
      vectors++; if (done_count !== base) begin miscompares++; $display("FAIL abort done pulses: got %0d expected 0", done_count - base); end
      a = $urandom();
      b = $urandom();
      do_op(2'd1, a, b, 1'b0, hi, lo, dz, lat);
      exp = model(2'd1, a, b);
      vectors++; if (lat !== 33)       begin miscompares++; $display("FAIL post-abort latency: got %0d expected 33", lat); end
      vectors++; if ({hi, lo} !== exp) begin miscompares++; $display("FAIL post-abort result: got %h_%h expected %h", hi, lo, exp); end
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
      logic [63:0] exp;
      logic        dz;
      int          lat;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom());
         a  = pick();
         b  = pick();
         do_op(op, a, b, 1'b0, hi, lo, dz, lat);
         exp = model(op, a, b);
         vectors++; if (lat !== 33)                   begin miscompares++; $display("FAIL random[%0d] latency: got %0d expected 33", i, lat); end
         vectors++; if ({hi, lo} !== exp)             begin miscompares++; $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h_%h expected %h", i, op, a, b, hi, lo, exp); end
         vectors++; if (dz !== (op[1] && b == 32'd0)) begin miscompares++; $display("FAIL random[%0d] dz: got %b expected %b", i, dz, op[1] && b == 32'd0); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_busy_start();
      test_back_to_back();
      test_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
